// File: rtl/flow_stats_pkg.sv
// Shared types for the flow statistics engine: FSM encoding, loss codes and
// the per-flow table entry layout.
package flow_stats_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_OUTPUT = 2'd3
    } state_e;

    localparam logic [1:0] LOSS_NONE  = 2'd0;
    localparam logic [1:0] LOSS_DUP   = 2'd2;
    localparam logic [1:0] LOSS_MULTI = 2'd3;

    // Entry fields are sized for the widest supported configuration; the
    // engine casts to its own parameter widths on read and write.
    localparam int ENT_SEQ_W = 32;
    localparam int ENT_TS_W  = 64;
    localparam int ENT_DUP_W = 8;

    typedef struct packed {
        logic [ENT_SEQ_W-1:0] seq;
        logic [ENT_TS_W-1:0]  ts;
        logic [ENT_SEQ_W-1:0] ack;
        logic [ENT_DUP_W-1:0] dupcnt;
    } entry_t;

endpackage

// File: rtl/flow_stats_div.sv
// Serial restoring divider: one quotient bit per cycle, DIV_W cycles after start.
// done_o is high during the final iteration; quotient_o is valid the cycle after.
module flow_stats_div #(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [DIV_W-1:0] dividend_i,
    input  logic [DIV_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [DIV_W-1:0] quotient_o
);

    localparam int CNT_W = $clog2(DIV_W + 1);

    logic [DIV_W-1:0] rem_q, rem_d;
    logic [DIV_W-1:0] quo_q, quo_d;
    logic [DIV_W-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [DIV_W:0]   trial;

    // The dividend shifts out of quo_q MSB-first while quotient bits shift in.
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        trial  = {rem_q, quo_q[DIV_W-1]} - {1'b0, dvs_q};
        if (start_i) begin
            rem_d  = '0;
            quo_d  = dividend_i;
            dvs_d  = divisor_i;
            cnt_d  = CNT_W'(DIV_W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (trial[DIV_W]) begin
                rem_d = {rem_q[DIV_W-2:0], quo_q[DIV_W-1]};
            end else begin
                rem_d = trial[DIV_W-1:0];
            end
            quo_d  = {quo_q[DIV_W-2:0], ~trial[DIV_W]};
            cnt_d  = cnt_q - 1'b1;
            busy_d = (cnt_q != CNT_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = busy_q && (cnt_q == CNT_W'(1));
    assign quotient_o = quo_q;

endmodule

// File: rtl/flow_stats_engine.sv
// Per-flow statistics engine: send rate, in-flight bytes and dup-ACK loss code.
// Optional FLOW_STATS_CLEAR_EN adds a per-flow valid-bit clear port.
//
// state  | meaning
// IDLE   | ready for a sample
// LOOKUP | read table entry, compute deltas, write entry back
// DIVIDE | serial divide of dseq by dts
// OUTPUT | result valid, held until downstream accepts
module flow_stats_engine
    import flow_stats_pkg::*;
#(
    parameter int N_FLOWS   = 128,
    parameter int ID_W      = 7,
    parameter int SEQ_W     = 32,
    parameter int TS_W      = 64,
    parameter int DIV_W     = 32,
    parameter int DUPACK_TH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_vld_in,
    output logic             sample_rdy_out,
    input  logic [ID_W-1:0]  sample_id_in,
    input  logic [SEQ_W-1:0] sample_seq_in,
    input  logic [SEQ_W-1:0] sample_ack_in,
    input  logic [TS_W-1:0]  sample_ts_in,
    output logic             stats_vld_out,
    input  logic             stats_rdy_in,
    output logic [ID_W-1:0]  stats_id_out,
    output logic [DIV_W-1:0] stats_rate_out,
    output logic [SEQ_W-1:0] stats_inflight_out,
    output logic [1:0]       stats_loss_out,
    output logic             stats_first_out
`ifdef FLOW_STATS_CLEAR_EN
    ,
    input  logic             clear_vld_in,
    input  logic [ID_W-1:0]  clear_id_in
`endif
);

    localparam logic [ENT_DUP_W-1:0] DUP_MAX = ENT_DUP_W'(DUPACK_TH - 1);

    state_e st_q, st_d;

    logic [ID_W-1:0]  id_q;
    logic [SEQ_W-1:0] seq_q, ack_q;
    logic [TS_W-1:0]  ts_q;

    logic [DIV_W-1:0] rate_q;
    logic [SEQ_W-1:0] inflight_q;
    logic [1:0]       loss_q;
    logic             first_q;
    logic             use_div_q;

    logic [N_FLOWS-1:0] vld_q;
    entry_t             tbl_q [N_FLOWS];

    entry_t                rd_ent, wr_ent;
    logic                  rd_vld;
    logic [SEQ_W-1:0]      dseq;
    logic [TS_W-1:0]       dts;
    logic                  dts_zero, dts_big, same_ack, bypass;
    logic [ENT_DUP_W-1:0]  dup_new;
    logic [1:0]            loss_new;

    logic             accept;
    logic             div_start, div_busy, div_done;
    logic [DIV_W-1:0] div_quo;

    assign accept = sample_vld_in && sample_rdy_out;

    always_comb begin
        rd_ent   = tbl_q[id_q];
        rd_vld   = vld_q[id_q];
        dseq     = seq_q - SEQ_W'(rd_ent.seq);
        dts      = ts_q - TS_W'(rd_ent.ts);
        dts_zero = (dts == '0);
        dts_big  = |(dts >> DIV_W);
        same_ack = rd_vld && (ack_q == SEQ_W'(rd_ent.ack));
        dup_new  = '0;
        if (same_ack) begin
            dup_new = (rd_ent.dupcnt >= DUP_MAX) ? DUP_MAX : rd_ent.dupcnt + 1'b1;
        end
        if (dup_new >= DUP_MAX) begin
            loss_new = LOSS_MULTI;
        end else if (dup_new != '0) begin
            loss_new = LOSS_DUP;
        end else begin
            loss_new = LOSS_NONE;
        end
        bypass        = !rd_vld || dts_zero || dts_big;
        wr_ent.seq    = ENT_SEQ_W'(seq_q);
        wr_ent.ts     = ENT_TS_W'(ts_q);
        wr_ent.ack    = ENT_SEQ_W'(ack_q);
        wr_ent.dupcnt = dup_new;
    end

    always_comb begin
        st_d      = st_q;
        div_start = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (sample_vld_in) st_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (bypass) begin
                    st_d = ST_OUTPUT;
                end else begin
                    div_start = 1'b1;
                    st_d      = ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                if (div_done || !div_busy) st_d = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (stats_rdy_in) st_d = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q       <= '0;
            seq_q      <= '0;
            ack_q      <= '0;
            ts_q       <= '0;
            rate_q     <= '0;
            inflight_q <= '0;
            loss_q     <= LOSS_NONE;
            first_q    <= 1'b0;
            use_div_q  <= 1'b0;
        end else begin
            if (accept) begin
                id_q  <= sample_id_in;
                seq_q <= sample_seq_in;
                ack_q <= sample_ack_in;
                ts_q  <= sample_ts_in;
            end
            if (st_q == ST_LOOKUP) begin
                inflight_q <= seq_q - ack_q;
                loss_q     <= loss_new;
                first_q    <= !rd_vld;
                use_div_q  <= !bypass;
                rate_q     <= (rd_vld && dts_zero) ? '1 : '0;
            end
        end
    end

    // Clear is applied before the LOOKUP set so a same-cycle write keeps the entry valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
`ifdef FLOW_STATS_CLEAR_EN
            if (clear_vld_in) vld_q[clear_id_in] <= 1'b0;
`endif
            if (st_q == ST_LOOKUP) vld_q[id_q] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (st_q == ST_LOOKUP) tbl_q[id_q] <= wr_ent;
    end

    flow_stats_div #(
        .DIV_W(DIV_W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start_i   (div_start),
        .dividend_i(DIV_W'(dseq)),
        .divisor_i (DIV_W'(dts)),
        .busy_o    (div_busy),
        .done_o    (div_done),
        .quotient_o(div_quo)
    );

    // The divider holds its quotient until the next start, which only comes from LOOKUP.
    assign sample_rdy_out     = (st_q == ST_IDLE) && !rst;
    assign stats_vld_out      = (st_q == ST_OUTPUT);
    assign stats_id_out       = id_q;
    assign stats_rate_out     = use_div_q ? div_quo : rate_q;
    assign stats_inflight_out = inflight_q;
    assign stats_loss_out     = loss_q;
    assign stats_first_out    = first_q;

endmodule
